pattern_history_table: RTL and testbench
========================================

# pattern_history_table

Second-level branch predictor that consumes the per-branch local history produced by `branch_history_table`. It indexes a table of 2-bit saturating counters with {PC bits, local history} and returns a taken/not-taken prediction to fetch in the same cycle. It keeps the index of every in-flight prediction so that in-order branch resolution updates the exact counter that made the prediction. It sits beside `branch_history_table` in fetch, with resolution fed back from execute.

## Interface
- `PHT_IDX_W`, 8: table index width; the table has 2^PHT_IDX_W counters.
- `HIST_W`, 4: local-history width; matches the `lc3b_bht_out` width.
- `INFLIGHT_DEPTH`, 4: maximum number of unresolved predictions; a power of two.
- Clocking: one clock; reset is synchronous and active-high.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pred_valid` in 1: fetch requests a prediction for a branch this cycle.
- `pc_pred_in` in 16 (`lc3b_word`): PC of the branch.
- `hist_in` in HIST_W: local history, taken from `bht_out`.
- `pred_ready` out 1: a prediction is accepted this cycle if `pred_valid` is high.
- `pred_taken` out 1: combinational prediction, the MSB of the indexed counter.
- `resolve_valid` in 1: the oldest in-flight branch has resolved.
- `resolve_taken` in 1: actual outcome of that branch.
- `flush` in 1: discard all in-flight predictions.
- `init_busy` out 1: table initialisation is in progress.
- `inflight_count` out log2(INFLIGHT_DEPTH)+1: number of in-flight predictions.
- `resolve_err` out 1: sticky flag; set when a resolve arrives while nothing is in flight.

## Operation
- Index: idx = {pc_pred_in[PHT_IDX_W-HIST_W:1], hist_in}. PC bit 0 is excluded.
- States:
  - INIT: an index counter walks 0 to 2^PHT_IDX_W-1, one entry per cycle, writing 2'b01 (weakly not-taken) to each entry. After the last entry is written, the state moves to READY.
  - READY: normal operation.
  - `reset` in any state returns to INIT, clears the FIFO, sets `inflight_count` to 0, clears `resolve_err`, and restarts the walk at entry 0.
- `pred_ready` = (state==READY) && (inflight_count < INFLIGHT_DEPTH). It does not depend on `resolve_valid` or `flush`.
- Accepted prediction (`pred_valid` && `pred_ready`):
  - idx is pushed into the in-flight FIFO.
  - `pred_taken` = ctr[idx][1].
  - When not ready, `pred_taken` = 0 and nothing is pushed.
- Resolve (`resolve_valid`, FIFO non-empty, state READY):
  - The oldest idx is popped.
  - The counter saturates: taken increments to a maximum of 3; not-taken decrements to a minimum of 0.
- Resolve with the FIFO empty, or in INIT:
  - No table change.
  - `resolve_err` is set.
- Simultaneous push and pop: both take effect; `inflight_count` is unchanged.
- `flush`:
  - Any resolve in the same cycle is applied first.
  - The FIFO is then emptied and `inflight_count` becomes 0.
  - A prediction accepted in the same cycle is returned to fetch but is not recorded.
- Prediction reading the same idx that a resolve updates in the same cycle: behaviour is set by `PHT_BYPASS_EN` (see Configuration).
- FIFO pointers wrap modulo INFLIGHT_DEPTH.

## Timing
- Values during `reset`:
  - `pred_ready` = 0, `init_busy` = 1, `pred_taken` = 0, `inflight_count` = 0.
  - `resolve_err` is 0 from the first edge with `reset` sampled high.
- Init length:
  - The first edge with `reset` low writes entry 0.
  - The edge that writes entry 2^PHT_IDX_W-1 enters READY.
  - `init_busy` falls and `pred_ready` rises exactly 2^PHT_IDX_W cycles after the first `reset`-low cycle (256 cycles by default).
- Prediction latency is 0 cycles: `pred_taken` is valid in the same cycle as `pred_valid`. The FIFO push and count update occur on that cycle's edge.
- A counter update is visible to a read in the next cycle.
- `inflight_count` and `resolve_err` are registered.

## Configuration
- `PHT_BYPASS_EN` defined:
  - If an accepted prediction's idx equals the idx being updated by a resolve in the same cycle, `pred_taken` reflects the post-update counter.
  - This adds a combinational path from `resolve_valid`/`resolve_taken` to `pred_taken`.
- `PHT_BYPASS_EN` undefined: `pred_taken` always reflects the pre-update counter (read-before-write).

## Structure
- `lc3b_types` gains:
  - `lc3b_pht_ind` (PHT_IDX_W bits).
  - `lc3b_pht_ctr` (2 bits).
  - `PHT_CTR_INIT` = 2'b01.
- Sub-module `pht_index_fifo`:
  - Parameterised by width and depth.
  - Provides push, pop and clear, plus count, full and empty outputs.
  - Has synchronous reset.
- The top level holds the init FSM, the counter array and the bypass logic.

## Test plan
- Reset released, `pred_valid` held high → `pred_ready` is 0 for 256 cycles, then 1. The first accepted prediction for any PC or history returns 0.
- PC=0x0010, hist=4'b0000 → idx 0x80. Two taken resolves (counter 01→10→11) → next prediction at the same idx is 1. Three more taken resolves leave the counter at 3. Three not-taken resolves (3→0) → prediction 0.
- Four predictions accepted with no resolve → `inflight_count`=4, `pred_ready`=0. One resolve → count 3 and `pred_ready`=1. Confirm the oldest idx was the one updated.
- Three in flight; `flush` asserted together with `resolve_valid`=1, taken, and a new prediction → only the oldest counter is updated, count goes to 0, and the new prediction is not recorded.
- `resolve_valid` with nothing in flight → no counter change, `resolve_err`=1, and it stays 1 until `reset`.
- Same-cycle prediction and taken resolve on idx at counter 01 → `pred_taken`=1 with `PHT_BYPASS_EN`, 0 without. Assert `reset` mid-traffic → init restarts and all counters return to 01.

Source files
------------

// File: rtl/pattern_history_table_pkg.sv
// Shared types for the two-level branch predictor's pattern history table.
// Latency: n/a (types and helper only). Backpressure: n/a.
// Holds counter/index types, the counter reset value and the saturating update.
package pattern_history_table_pkg;

    localparam int LC3B_PHT_IDX_W = 8;

    typedef logic [15:0]               lc3b_word;
    typedef logic [LC3B_PHT_IDX_W-1:0] lc3b_pht_ind;
    typedef logic [1:0]                lc3b_pht_ctr;

    localparam lc3b_pht_ctr PHT_CTR_INIT = 2'b01;

    typedef enum logic {
        PHT_INIT  = 1'b0,
        PHT_READY = 1'b1
    } pht_state_e;

    function automatic lc3b_pht_ctr ctr_sat_update(input lc3b_pht_ctr ctr, input logic taken);
        lc3b_pht_ctr res;
        res = ctr;
        if (taken && ctr != 2'b11) begin
            res = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            res = ctr - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/pht_index_fifo.sv
// In-order FIFO of table indices for predictions awaiting resolution.
// Latency: push visible at the head on the next cycle. Backpressure: push ignored when full.
// Clear wins over push/pop in the same cycle; DEPTH must be a power of two >= 2.
module pht_index_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    input  logic                     clear,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, do_pop};
        count_d  = count_q + {{(CNT_W-1){1'b0}}, do_push} - {{(CNT_W-1){1'b0}}, do_pop};
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push && !clear) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/pattern_history_table.sv
// Pattern history table: 2-bit counters indexed by {PC, local history}; PHT_BYPASS_EN forwards same-cycle updates.
// Latency: prediction combinational (0 cycles); counter updates visible next cycle.
// Backpressure: pred_ready low during init walk or when INFLIGHT_DEPTH predictions are unresolved.
module pattern_history_table
    import pattern_history_table_pkg::*;
#(
    parameter int PHT_IDX_W      = 8,
    parameter int HIST_W         = 4,
    parameter int INFLIGHT_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pred_valid,
    input  lc3b_word                          pc_pred_in,
    input  logic [HIST_W-1:0]                 hist_in,
    output logic                              pred_ready,
    output logic                              pred_taken,
    input  logic                              resolve_valid,
    input  logic                              resolve_taken,
    input  logic                              flush,
    output logic                              init_busy,
    output logic [$clog2(INFLIGHT_DEPTH):0]   inflight_count,
    output logic                              resolve_err
);

    localparam int ENTRIES = 2 ** PHT_IDX_W;

    pht_state_e            state_q, state_d;
    logic [PHT_IDX_W-1:0]  init_idx_q, init_idx_d;
    logic                  resolve_err_q, resolve_err_d;
    lc3b_pht_ctr           ctr_q [ENTRIES];

    logic                  is_ready;
    logic [PHT_IDX_W-1:0]  pred_idx;
    logic [PHT_IDX_W-1:0]  upd_idx;
    lc3b_pht_ctr           upd_dat;
    logic                  upd_en;
    logic                  ctr_wr_en;
    logic [PHT_IDX_W-1:0]  ctr_wr_idx;
    lc3b_pht_ctr           ctr_wr_dat;
    lc3b_pht_ctr           rd_ctr;
    logic                  fifo_full, fifo_empty, fifo_push;
    logic                  unused_pc_bits;

    // PC bit 0 and the bits above the index window do not participate.
    assign unused_pc_bits = ^{pc_pred_in[15:PHT_IDX_W-HIST_W+1], pc_pred_in[0]};
    assign pred_idx       = {pc_pred_in[PHT_IDX_W-HIST_W:1], hist_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= PHT_INIT;
            init_idx_q    <= '0;
            resolve_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            resolve_err_q <= resolve_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == PHT_INIT) begin
            init_idx_d = init_idx_q + 1'b1;
            if (&init_idx_q) begin
                state_d = PHT_READY;
            end
        end
    end

    always_comb begin
        init_busy = (state_q == PHT_INIT);
        is_ready  = (state_q == PHT_READY);
    end

    assign pred_ready = is_ready && !fifo_full;

    always_comb begin
        upd_en        = resolve_valid && is_ready && !fifo_empty;
        upd_dat       = ctr_sat_update(ctr_q[upd_idx], resolve_taken);
        resolve_err_d = resolve_err_q | (resolve_valid && !upd_en);
        ctr_wr_en     = upd_en;
        ctr_wr_idx    = upd_idx;
        ctr_wr_dat    = upd_dat;
        if (init_busy) begin
            ctr_wr_en  = 1'b1;
            ctr_wr_idx = init_idx_q;
            ctr_wr_dat = PHT_CTR_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && ctr_wr_en) begin
            ctr_q[ctr_wr_idx] <= ctr_wr_dat;
        end
    end

    always_comb begin
        rd_ctr = ctr_q[pred_idx];
`ifdef PHT_BYPASS_EN
        if (upd_en && upd_idx == pred_idx) begin
            rd_ctr = upd_dat;
        end
`endif
        pred_taken = pred_ready && rd_ctr[1];
    end

    // A prediction accepted under flush is returned but never tracked.
    assign fifo_push = pred_valid && pred_ready && !flush;

    pht_index_fifo #(
        .W     (PHT_IDX_W),
        .DEPTH (INFLIGHT_DEPTH)
    ) u_index_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (pred_idx),
        .pop      (upd_en),
        .clear    (flush),
        .pop_dat  (upd_idx),
        .count    (inflight_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign resolve_err = resolve_err_q;

endmodule

// File: tb/tb_pattern_history_table.sv
// Randomised bench for pattern_history_table against an array/queue reference model.
module tb_pattern_history_table;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic [15:0] pc_pred_in;
    logic [3:0]  hist_in;
    logic        pred_ready;
    logic        pred_taken;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        flush;
    logic        init_busy;
    logic [2:0]  inflight_count;
    logic        resolve_err;

    pattern_history_table dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pc_pred_in     (pc_pred_in),
        .hist_in        (hist_in),
        .pred_ready     (pred_ready),
        .pred_taken     (pred_taken),
        .resolve_valid  (resolve_valid),
        .resolve_taken  (resolve_taken),
        .flush          (flush),
        .init_busy      (init_busy),
        .inflight_count (inflight_count),
        .resolve_err    (resolve_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: counters as integers 0..3, in-flight indices as a queue,
    // init progress as the number of entries written since reset.
    int ctr [256];
    int inflight [$];
    int walk;
    bit err;
    bit known;

    function automatic int sat(input int c, input bit taken);
        if (taken) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic run_cycle(input int p_res, input int p_flush);
        int  idx, c, head;
        bit  m_ready, exp_ready, exp_taken;
        @(posedge clk);
        #1;
        reset         = 1'b0;
        pred_valid    = ($urandom_range(0, 99) < 70);
        pc_pred_in    = 16'($urandom);
        hist_in       = 4'($urandom);
        if ($urandom_range(0, 3) != 0) begin
            pc_pred_in[4:1] = 4'($urandom_range(0, 1));
            hist_in         = 4'($urandom_range(0, 1));
        end
        resolve_valid = ($urandom_range(0, 99) < p_res);
        resolve_taken = ($urandom_range(0, 99) < 60);
        flush         = ($urandom_range(0, 99) < p_flush);
        #1;
        idx       = (((pc_pred_in >> 1) & 15) << 4) | hist_in;
        m_ready   = (walk == 256);
        exp_ready = m_ready && (inflight.size() < 4);
        exp_taken = 1'b0;
        if (exp_ready) begin
            c = ctr[idx];
`ifdef PHT_BYPASS_EN
            if (resolve_valid && inflight.size() > 0 && inflight[0] == idx)
                c = sat(ctr[idx], resolve_taken);
`endif
            exp_taken = (c >= 2);
        end
        if (known) begin
            check_eq("pred_ready", int'(pred_ready), int'(exp_ready));
            check_eq("init_busy", int'(init_busy), int'(!m_ready));
            check_eq("pred_taken", int'(pred_taken), int'(exp_taken));
            check_eq("inflight_count", int'(inflight_count), inflight.size());
            check_eq("resolve_err", int'(resolve_err), int'(err));
        end
        if (!m_ready) begin
            ctr[walk] = 1;
            walk++;
        end
        if (resolve_valid) begin
            if (m_ready && inflight.size() > 0) begin
                head = inflight.pop_front();
                ctr[head] = sat(ctr[head], resolve_taken);
            end else begin
                err = 1'b1;
            end
        end
        if (pred_valid && exp_ready && !flush) inflight.push_back(idx);
        if (flush) inflight.delete();
    endtask

    task automatic reset_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset         = 1'b1;
            pred_valid    = 1'b1;
            pc_pred_in    = 16'($urandom);
            hist_in       = 4'($urandom);
            resolve_valid = 1'b1;
            resolve_taken = 1'b1;
            flush         = 1'b0;
            #1;
            if (known) begin
                // First reset cycle may still show pre-reset state; later ones must be in INIT.
                if (i > 0) begin
                    check_eq("rst_pred_ready", int'(pred_ready), 0);
                    check_eq("rst_init_busy", int'(init_busy), 1);
                    check_eq("rst_pred_taken", int'(pred_taken), 0);
                    check_eq("rst_inflight_count", int'(inflight_count), 0);
                    check_eq("rst_resolve_err", int'(resolve_err), 0);
                end
            end
            inflight.delete();
            err   = 1'b0;
            walk  = 0;
            known = 1'b1;
        end
    endtask

    initial begin
        int p_res [4] = '{10, 40, 70, 35};
        reset         = 1'b1;
        pred_valid    = 1'b0;
        pc_pred_in    = '0;
        hist_in       = '0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        flush         = 1'b0;
        known         = 1'b0;
        walk          = 0;
        err           = 1'b0;
        for (int seg = 0; seg < 4; seg++) begin
            reset_cycles(3);
            for (int cyc = 0; cyc < 700; cyc++) begin
                // Hold off resolves during the walk at first so the sticky error starts clear.
                if (walk < 256 && seg == 0)
                    run_cycle(0, 0);
                else
                    run_cycle(p_res[seg], (seg == 3) ? 8 : 3);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
